// File: rtl/clk_pkg.sv
// Shared BCD types, digit arithmetic helpers and field moduli for the clock datapath.
// Helpers are pure functions, usable both in logic and in constant expressions.
package clk_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } bcd2_t;

  localparam int SEC_MOD  = 60;
  localparam int HR24_MOD = 24;
  localparam int HR12_MOD = 12;
  localparam int HR12_MIN = 1;

  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.units == 4'd9) begin
      r.units = 4'd0;
      r.tens  = v.tens + 4'd1;
    end else begin
      r.units = v.units + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd2_t bcd2_dec(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.units == 4'd0) begin
      r.units = 4'd9;
      r.tens  = v.tens - 4'd1;
    end else begin
      r.units = v.units - 4'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd2_to_bin(input bcd2_t v);
    return 8'(v.tens) * 8'd10 + 8'(v.units);
  endfunction

  function automatic bcd2_t bin_to_bcd2(input int v);
    bcd2_t r;
    r.tens  = 4'(v / 10);
    r.units = 4'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// Control/status bundle of one BCD time-field counter.
// master = controlling side (timebase, UI, cascade consumer); slave = the counter.
interface bcd_mod_counter_if;
  import clk_pkg::*;

  logic EN;
  logic UP;
  logic INC;
  logic DEC;
  logic LOAD;
  bcd_t LDH;
  bcd_t LDL;
  bcd_t QH;
  bcd_t QL;
  logic CA;
  logic BO;
  logic LDERR;

  modport master (
    output EN, UP, INC, DEC, LOAD, LDH, LDL,
    input  QH, QL, CA, BO, LDERR
  );

  modport slave (
    input  EN, UP, INC, DEC, LOAD, LDH, LDL,
    output QH, QL, CA, BO, LDERR
  );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (MINVAL..MINVAL+MODULUS-1) with up/down step, manual set and load.
// Count updates one cycle after its control input; CA/BO are same-cycle so a next field can use CA as EN.
module bcd_mod_counter
  import clk_pkg::*;
#(
  parameter int MODULUS = 60,
  parameter int MINVAL  = 0
) (
  input logic             CLK,
  input logic             RST,
  bcd_mod_counter_if.slave bus
);

  localparam int    MAXVAL  = MINVAL + MODULUS - 1;
  localparam bcd2_t MIN_BCD = bin_to_bcd2(MINVAL);
  localparam bcd2_t MAX_BCD = bin_to_bcd2(MAXVAL);
  localparam logic [7:0] MIN_BIN = 8'(MINVAL);
  localparam logic [7:0] MOD_BIN = 8'(MODULUS);

  generate
    if (MAXVAL > 99 || MODULUS < 2 || MINVAL < 0) begin : g_bad_params
      $fatal(1, "bcd_mod_counter: MODULUS/MINVAL out of range (MAXVAL must be <= 99, MODULUS >= 2)");
    end
  endgenerate

  bcd2_t      cnt;
  bcd2_t      nxt;
  bcd2_t      ld_bcd;
  bcd2_t      step_up;
  bcd2_t      step_dn;
  logic [7:0] ld_off;
  logic       ld_ok;
  logic       at_max;
  logic       at_min;
  logic       lderr_q;
  logic       lderr_nxt;

  assign at_max  = (cnt == MAX_BCD);
  assign at_min  = (cnt == MIN_BCD);
  assign step_up = at_max ? MIN_BCD : bcd2_inc(cnt);
  assign step_dn = at_min ? MAX_BCD : bcd2_dec(cnt);

  assign ld_bcd.tens  = bus.LDH;
  assign ld_bcd.units = bus.LDL;
  // Values below MINVAL wrap to >= 157 in 8 bits, so one compare covers both range bounds.
  assign ld_off = bcd2_to_bin(ld_bcd) - MIN_BIN;
  assign ld_ok  = (bus.LDH <= 4'd9) && (bus.LDL <= 4'd9) && (ld_off < MOD_BIN);

  always_comb begin
    nxt       = cnt;
    lderr_nxt = 1'b0;
    if (bus.LOAD) begin
      if (ld_ok) begin
        nxt = ld_bcd;
      end else begin
        lderr_nxt = 1'b1;
      end
    end else if (bus.EN) begin
      nxt = bus.UP ? step_up : step_dn;
    end else if (bus.INC && !bus.DEC) begin
      nxt = step_up;
    end else if (bus.DEC && !bus.INC) begin
      nxt = step_dn;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt <= MIN_BCD;
    end else begin
      cnt <= nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      lderr_q <= 1'b0;
    end else begin
      lderr_q <= lderr_nxt;
    end
  end

  assign bus.QH    = cnt.tens;
  assign bus.QL    = cnt.units;
  assign bus.LDERR = lderr_q;
  assign bus.CA    = RST && !bus.LOAD && bus.EN &&  bus.UP && at_max;
  assign bus.BO    = RST && !bus.LOAD && bus.EN && !bus.UP && at_min;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: three field configurations (sec, 12 h, 24 h) against an integer reference model.
module tb_bcd_mod_counter;
  import clk_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  bcd_mod_counter_if if60 ();
  bcd_mod_counter_if if12 ();
  bcd_mod_counter_if if24 ();

  bcd_mod_counter #(.MODULUS(SEC_MOD),  .MINVAL(0))        u60 (.CLK(CLK), .RST(RST), .bus(if60.slave));
  bcd_mod_counter #(.MODULUS(HR12_MOD), .MINVAL(HR12_MIN)) u12 (.CLK(CLK), .RST(RST), .bus(if12.slave));
  bcd_mod_counter #(.MODULUS(HR24_MOD), .MINVAL(0))        u24 (.CLK(CLK), .RST(RST), .bus(if24.slave));

  virtual bcd_mod_counter_if vif;

  int m_mod;
  int m_min;
  int m_val;

  logic [7:0] obs_q,  exp_q;
  logic       obs_ca, exp_ca;
  logic       obs_bo, exp_bo;
  logic       obs_err, exp_err;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int wrap(input int x);
    return m_min + ((x - m_min + m_mod) % m_mod);
  endfunction

  task automatic clear_if(input virtual bcd_mod_counter_if v);
    v.EN = 1'b0; v.UP = 1'b0; v.INC = 1'b0; v.DEC = 1'b0;
    v.LOAD = 1'b0; v.LDH = 4'd0; v.LDL = 4'd0;
  endtask

  task automatic select(input int which);
    case (which)
      0:       begin vif = if60; m_mod = SEC_MOD;  m_min = 0;        end
      1:       begin vif = if12; m_mod = HR12_MOD; m_min = HR12_MIN; end
      default: begin vif = if24; m_mod = HR24_MOD; m_min = 0;        end
    endcase
    m_val = m_min;
  endtask

  // Drives one cycle, records observed outputs and the model's expectation for them.
  task automatic run_cycle(input bit rst, input bit en, input bit up, input bit inc, input bit dec,
                           input bit load, input logic [3:0] ldh, input logic [3:0] ldl);
    int maxv, lv, nv;
    bit ok;
    @(negedge CLK);
    RST = rst; vif.EN = en; vif.UP = up; vif.INC = inc; vif.DEC = dec;
    vif.LOAD = load; vif.LDH = ldh; vif.LDL = ldl;
    #2;
    obs_ca = vif.CA;
    obs_bo = vif.BO;
    maxv   = m_min + m_mod - 1;
    exp_ca = rst && !load && en &&  up && (m_val == maxv);
    exp_bo = rst && !load && en && !up && (m_val == m_min);
    exp_err = 1'b0;
    nv = m_val;
    if (!rst) begin
      nv = m_min;
    end else if (load) begin
      lv = int'(ldh) * 10 + int'(ldl);
      ok = (ldh <= 9) && (ldl <= 9) && (lv >= m_min) && (lv <= maxv);
      if (ok) nv = lv;
      exp_err = !ok;
    end else if (en) begin
      nv = wrap(up ? m_val + 1 : m_val - 1);
    end else if (inc && !dec) begin
      nv = wrap(m_val + 1);
    end else if (dec && !inc) begin
      nv = wrap(m_val - 1);
    end
    @(posedge CLK);
    #1;
    m_val   = nv;
    exp_q   = {4'(nv / 10), 4'(nv % 10)};
    obs_q   = {vif.QH, vif.QL};
    obs_err = vif.LDERR;
  endtask

  task automatic test_reset();
    select(0);
    run_cycle(0, 1, 1, 0, 0, 0, 4'd0, 4'd0);
    n_tests++;
    if (obs_ca !== 1'b0) begin n_fail++; $display("FAIL reset_ca: got %b want 0", obs_ca); end
    n_tests++;
    if (obs_q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h want 00", obs_q); end
    n_tests++;
    if (obs_err !== 1'b0) begin n_fail++; $display("FAIL reset_lderr: got %b want 0", obs_err); end
  endtask

  task automatic test_count_up60();
    int ca_hits;
    int bad;
    select(0);
    run_cycle(0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
    ca_hits = 0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      run_cycle(1, 1, 1, 0, 0, 0, 4'd0, 4'd0);
      if (obs_ca === 1'b1) ca_hits++;
      if (obs_q !== exp_q || obs_ca !== exp_ca) begin
        bad++;
        $display("FAIL up60_step%0d: got q=%h ca=%b want q=%h ca=%b", i, obs_q, obs_ca, exp_q, exp_ca);
      end
    end
    n_tests++;
    if (bad != 0) n_fail++;
    n_tests++;
    if (ca_hits != 1) begin n_fail++; $display("FAIL up60_ca_count: got %0d want 1", ca_hits); end
    n_tests++;
    if (obs_q !== 8'h00) begin n_fail++; $display("FAIL up60_wrap: got %h want 00", obs_q); end
  endtask

  task automatic test_mod12();
    int ca_hits;
    select(1);
    run_cycle(0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
    n_tests++;
    if (obs_q !== 8'h01) begin n_fail++; $display("FAIL h12_reset: got %h want 01", obs_q); end
    run_cycle(1, 1, 0, 0, 0, 0, 4'd0, 4'd0);
    n_tests++;
    if (obs_bo !== 1'b1) begin n_fail++; $display("FAIL h12_bo: got %b want 1", obs_bo); end
    n_tests++;
    if (obs_q !== 8'h12) begin n_fail++; $display("FAIL h12_down_wrap: got %h want 12", obs_q); end
    ca_hits = 0;
    for (int i = 0; i < 12; i++) begin
      run_cycle(1, 1, 1, 0, 0, 0, 4'd0, 4'd0);
      if (obs_ca === 1'b1) ca_hits++;
      n_tests++;
      if (obs_q !== exp_q || obs_ca !== exp_ca) begin
        n_fail++;
        $display("FAIL h12_up%0d: got q=%h ca=%b want q=%h ca=%b", i, obs_q, obs_ca, exp_q, exp_ca);
      end
    end
    n_tests++;
    if (ca_hits != 1 || obs_q !== 8'h12) begin
      n_fail++;
      $display("FAIL h12_full_lap: got q=%h ca_hits=%0d want q=12 ca_hits=1", obs_q, ca_hits);
    end
  endtask

  task automatic test_mod24_manual();
    select(2);
    run_cycle(0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
    run_cycle(1, 0, 0, 0, 0, 1, 4'd2, 4'd3);
    n_tests++;
    if (obs_q !== 8'h23) begin n_fail++; $display("FAIL h24_load: got %h want 23", obs_q); end
    run_cycle(1, 0, 1, 1, 0, 0, 4'd0, 4'd0);
    n_tests++;
    if (obs_q !== 8'h00 || obs_ca !== 1'b0) begin
      n_fail++; $display("FAIL h24_inc_wrap: got q=%h ca=%b want q=00 ca=0", obs_q, obs_ca);
    end
    run_cycle(1, 0, 0, 0, 1, 0, 4'd0, 4'd0);
    n_tests++;
    if (obs_q !== 8'h23 || obs_bo !== 1'b0) begin
      n_fail++; $display("FAIL h24_dec_wrap: got q=%h bo=%b want q=23 bo=0", obs_q, obs_bo);
    end
    run_cycle(1, 0, 0, 1, 1, 0, 4'd0, 4'd0);
    n_tests++;
    if (obs_q !== 8'h23) begin n_fail++; $display("FAIL h24_inc_dec_hold: got %h want 23", obs_q); end
  endtask

  task automatic test_load_err();
    select(0);
    run_cycle(0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
    run_cycle(1, 0, 0, 0, 0, 1, 4'd4, 4'd5);
    n_tests++;
    if (obs_q !== 8'h45 || obs_err !== 1'b0) begin
      n_fail++; $display("FAIL ld_valid: got q=%h err=%b want q=45 err=0", obs_q, obs_err);
    end
    run_cycle(1, 1, 1, 0, 0, 1, 4'd6, 4'd0);
    n_tests++;
    if (obs_q !== 8'h45 || obs_err !== 1'b1 || obs_ca !== 1'b0) begin
      n_fail++; $display("FAIL ld_60: got q=%h err=%b ca=%b want q=45 err=1 ca=0", obs_q, obs_err, obs_ca);
    end
    run_cycle(1, 0, 0, 0, 0, 0, 4'd0, 4'd0);
    n_tests++;
    if (obs_err !== 1'b0) begin n_fail++; $display("FAIL ld_err_pulse: got %b want 0", obs_err); end
    run_cycle(1, 0, 0, 0, 0, 1, 4'd0, 4'd10);
    n_tests++;
    if (obs_q !== 8'h45 || obs_err !== 1'b1) begin
      n_fail++; $display("FAIL ld_nonbcd: got q=%h err=%b want q=45 err=1", obs_q, obs_err);
    end
  endtask

  task automatic test_collisions();
    select(0);
    run_cycle(0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
    run_cycle(1, 0, 0, 0, 0, 1, 4'd5, 4'd8);
    run_cycle(1, 1, 1, 1, 0, 0, 4'd0, 4'd0);
    n_tests++;
    if (obs_q !== 8'h59) begin n_fail++; $display("FAIL en_inc_single: got %h want 59", obs_q); end
    run_cycle(1, 1, 1, 0, 0, 1, 4'd1, 4'd2);
    n_tests++;
    if (obs_q !== 8'h12 || obs_ca !== 1'b0) begin
      n_fail++; $display("FAIL load_over_en: got q=%h ca=%b want q=12 ca=0", obs_q, obs_ca);
    end
  endtask

  task automatic test_reset_mid();
    select(0);
    run_cycle(0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
    run_cycle(1, 0, 0, 0, 0, 1, 4'd3, 4'd7);
    run_cycle(0, 1, 1, 0, 0, 0, 4'd0, 4'd0);
    n_tests++;
    if (obs_q !== 8'h00 || obs_ca !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: got q=%h ca=%b want q=00 ca=0", obs_q, obs_ca);
    end
    run_cycle(0, 1, 1, 0, 0, 0, 4'd0, 4'd0);
    n_tests++;
    if (obs_q !== 8'h00) begin n_fail++; $display("FAIL rst_hold: got %h want 00", obs_q); end
    run_cycle(1, 1, 1, 0, 0, 0, 4'd0, 4'd0);
    n_tests++;
    if (obs_q !== 8'h01) begin n_fail++; $display("FAIL rst_resume: got %h want 01", obs_q); end
    run_cycle(1, 0, 0, 0, 0, 1, 4'd9, 4'd9);
    run_cycle(0, 0, 0, 0, 0, 1, 4'd9, 4'd9);
    n_tests++;
    if (obs_err !== 1'b0 || obs_q !== 8'h00) begin
      n_fail++; $display("FAIL rst_clears_lderr: got err=%b q=%h want err=0 q=00", obs_err, obs_q);
    end
  endtask

  task automatic test_random();
    bit r_rst, r_en, r_up, r_inc, r_dec, r_ld;
    logic [3:0] r_h, r_l;
    for (int d = 0; d < 3; d++) begin
      select(d);
      run_cycle(0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
      for (int i = 0; i < 400; i++) begin
        r_rst = ($urandom % 25) != 0;
        r_en  = ($urandom % 3) == 0;
        r_up  = $urandom % 2;
        r_inc = ($urandom % 3) == 0;
        r_dec = ($urandom % 3) == 0;
        r_ld  = ($urandom % 8) == 0;
        r_h   = 4'($urandom % 11);
        r_l   = 4'($urandom % 11);
        run_cycle(r_rst, r_en, r_up, r_inc, r_dec, r_ld, r_h, r_l);
        n_tests++;
        if (obs_q !== exp_q || obs_ca !== exp_ca || obs_bo !== exp_bo || obs_err !== exp_err) begin
          n_fail++;
          $display("FAIL rand_d%0d_c%0d: got q=%h ca=%b bo=%b err=%b want q=%h ca=%b bo=%b err=%b",
                   d, i, obs_q, obs_ca, obs_bo, obs_err, exp_q, exp_ca, exp_bo, exp_err);
        end
      end
      clear_if(vif);
    end
  endtask

  initial begin
    clear_if(if60);
    clear_if(if12);
    clear_if(if24);
    test_reset();
    test_count_up60();
    clear_if(if60);
    test_mod12();
    clear_if(if12);
    test_mod24_manual();
    clear_if(if24);
    test_load_err();
    test_collisions();
    test_reset_mid();
    clear_if(if60);
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
Parametrised two-digit BCD modulo counter, the next-generation time-field counter for the clock datapath. One instance covers seconds and minutes (0..59), 24 h hours (0..23) and 12 h hours (1..12). Supports up/down counting on the timebase enable, manual set via INC/DEC, parallel load, and carry/borrow outputs for cascading to the next field.

Parameters:
MODULUS, 60, number of distinct states (2..99).
MINVAL, 0, first/lowest count value; MAXVAL = MINVAL+MODULUS-1, must be <= 99.

Ports:
CLK  in  1  system clock, all state changes on rising edge.
RST  in  1  synchronous reset, active-low; sampled on rising CLK.
EN  in  1  timebase tick; steps the count in direction UP.
UP  in  1  direction for EN steps: 1 = count up, 0 = count down.
INC  in  1  manual set +1 (wraps, never produces CA).
DEC  in  1  manual set -1 (wraps, never produces BO).
LOAD  in  1  parallel load request.
LDH  in  4  BCD tens digit for load.
LDL  in  4  BCD units digit for load.
QH  out  4  BCD tens digit of count (registered).
QL  out  4  BCD units digit of count (registered).
CA  out  1  carry: count==MAXVAL && EN && UP && no load/reset this cycle (combinational).
BO  out  1  borrow: count==MINVAL && EN && !UP && no load/reset this cycle (combinational).
LDERR  out  1  registered one-cycle pulse: previous cycle's LOAD value was rejected.

Behaviour:
- Priority per rising edge: RST==0 > LOAD > EN > INC/DEC.
- Reset: {QH,QL} <= BCD(MINVAL); LDERR <= 0. CA and BO are 0 while RST==0.
- LOAD: valid if LDH<=9, LDL<=9 and MINVAL <= 10*LDH+LDL <= MAXVAL. Valid value loads next edge, LDERR <= 0. Invalid value: count held, LDERR <= 1 for exactly one cycle. EN/INC/DEC are ignored in any LOAD cycle. CA/BO are forced 0.
- EN with UP=1: count==MAXVAL -> MINVAL, else +1. CA high in that same cycle only at MAXVAL.
- EN with UP=0: count==MINVAL -> MAXVAL, else -1. BO high in that same cycle only at MINVAL.
- INC/DEC are honoured only when EN==0 and LOAD==0. Each applies the same wrap rule as an EN step. INC&&DEC together: hold. CA/BO stay 0.
- A manual press coincident with EN is dropped: no double step.
- BCD arithmetic: units 9->0 with tens+1 on increment; units 0->9 with tens-1 on decrement. QL never exceeds 9.
- Latency: one cycle from control input to new QH/QL. CA/BO are same-cycle combinational, so the downstream counter's EN can be tied directly to CA.
- Reset mid-operation overrides everything, including a pending LDERR.
- Elaboration-time check: MAXVAL>99 or MODULUS<2 is a fatal error.

Decomposition:
- Shared package clk_pkg:
  - bcd_t (4-bit digit) and bcd2_t (tens,units) typedefs.
  - Functions bcd2_inc, bcd2_dec, bcd2_to_bin and bin_to_bcd2.
  - Constants SEC_MOD=60, HR24_MOD=24, HR12_MOD=12, HR12_MIN=1.
- No sub-module. Next-state select is one combinational block feeding one register block; LDERR is a separate small register.

Test Plan:
- Default (60,0): reset, then 60 EN pulses with UP=1 -> counts 00..59. CA=1 only while at 59. Wraps to 00.
- MODULUS=12, MINVAL=1: reset -> 01. EN down once -> 12 with BO=1 in the preceding cycle. 12 EN up -> back to 12, CA at 12.
- MODULUS=24: LOAD 2,3 -> 23. INC -> 00 with CA=0. DEC -> 23. INC+DEC together -> stays 23.
- LOAD 6,0 on (60,0) -> count held, LDERR=1 one cycle. LOAD 0,10 (non-BCD) -> held, LDERR=1.
- EN and INC same cycle at 58, UP=1 -> 59, not 00. LOAD and EN same cycle at 59 -> loaded value, CA=0.
- RST=0 asserted while count=37, EN=1 -> next edge 00. CA=0 during reset. Count resumes only after RST=1.
